// File: rtl/verinject_pkg.sv
// Shared definitions for the verinject injection domain.
// Bus codes on verinject__injector_state and the controller FSM state type.
package verinject_pkg;

  // No injection this cycle.
  localparam logic [31:0] VERINJECT_STATE_IDLE  = 32'hFFFF_FFFF;
  // Wipe every memory injector FIFO.
  localparam logic [31:0] VERINJECT_STATE_CLEAR = 32'hFFFF_FFFE;

  // StAbort is the clear cycle that follows an abort; it returns to StIdle.
  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StDone,
    StAbort
  } ctrl_state_e;

endpackage

// File: rtl/verinject_schedule_buffer.sv
// Schedule storage for the injection controller.
// Holds (cycle, bit) entries in load order, enforces the non-decreasing cycle order and the
// legal bit range, and exposes the entry at the read pointer.
// Ports:
//   clock_i, reset_i    : clock, synchronous active-high reset
//   clear_i             : empty the schedule (wins over a same-cycle write)
//   wr_valid_i          : a load handshake completes this cycle
//   wr_cycle_i/wr_bit_i : offered entry
//   wr_store_o          : the offered entry is stored this cycle
//   wr_reject_o         : the offered entry violates range or order
//   rewind_i/advance_i  : read pointer to entry 0 / to the next entry
//   count_o             : stored entry count
//   head_valid_o        : read pointer has not reached the end
//   head_cycle_o/head_bit_o : entry at the read pointer
module verinject_schedule_buffer
  import verinject_pkg::*;
#(
  parameter int unsigned Depth      = 16,
  parameter int unsigned CycleWidth = 24,
  localparam int unsigned AddrWidth = $clog2(Depth)
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  clear_i,
  input  logic                  wr_valid_i,
  input  logic [CycleWidth-1:0] wr_cycle_i,
  input  logic [31:0]           wr_bit_i,
  output logic                  wr_store_o,
  output logic                  wr_reject_o,
  input  logic                  rewind_i,
  input  logic                  advance_i,
  output logic [AddrWidth:0]    count_o,
  output logic                  head_valid_o,
  output logic [CycleWidth-1:0] head_cycle_o,
  output logic [31:0]           head_bit_o
);

  logic [CycleWidth-1:0] cycle_mem [Depth];
  logic [31:0]           bit_mem   [Depth];
  logic [AddrWidth:0]    count_q;
  logic [AddrWidth:0]    rd_ptr_q;
  logic [CycleWidth-1:0] last_cycle_q;

  // Order is only checked against an entry that is still stored.
  assign wr_reject_o = (wr_bit_i >= VERINJECT_STATE_CLEAR) ||
                       ((count_q != '0) && (wr_cycle_i < last_cycle_q));
  assign wr_store_o  = wr_valid_i && !clear_i && !wr_reject_o;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_q      <= '0;
      rd_ptr_q     <= '0;
      last_cycle_q <= '0;
    end else begin
      if (clear_i) begin
        count_q <= '0;
      end else if (wr_store_o) begin
        count_q      <= count_q + 1'b1;
        last_cycle_q <= wr_cycle_i;
      end
      if (clear_i || rewind_i) begin
        rd_ptr_q <= '0;
      end else if (advance_i) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Writes only happen while count_q < Depth, so the low bits address the free slot.
  always_ff @(posedge clock_i) begin
    if (wr_store_o) begin
      cycle_mem[count_q[AddrWidth-1:0]] <= wr_cycle_i;
      bit_mem[count_q[AddrWidth-1:0]]   <= wr_bit_i;
    end
  end

  assign count_o      = count_q;
  assign head_valid_o = (rd_ptr_q != count_q);
  assign head_cycle_o = cycle_mem[rd_ptr_q[AddrWidth-1:0]];
  assign head_bit_o   = bit_mem[rd_ptr_q[AddrWidth-1:0]];

endmodule

// File: rtl/verinject_injection_controller.sv
// Schedule-driven driver of the verinject__injector_state bus.
// Software loads (cycle, bit) events; start broadcasts the clear code for one cycle and then
// replays the events cycle-accurately, at most one per cycle.
// Ports:
//   clock, reset              : clock, synchronous active-high reset
//   load_valid/load_ready     : schedule load handshake with load_cycle/load_bit
//   sched_clear               : empty schedule, clear load_error and late_count (IDLE/DONE)
//   start, abort              : begin a run / terminate a run
//   verinject__injector_state : registered state bus
//   busy, done                : run in progress / run finished
//   entry_count               : stored entries
//   late_count                : events emitted after their stamp (saturating)
//   load_error                : sticky, a load was rejected
// All outputs are registers or decodes of registers only.
module verinject_injection_controller
  import verinject_pkg::*;
#(
  parameter int unsigned SCHEDULE_DEPTH = 16,
  parameter int unsigned CYCLE_WIDTH    = 24
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [CYCLE_WIDTH-1:0]        load_cycle,
  input  logic [31:0]                   load_bit,
  input  logic                          sched_clear,
  input  logic                          start,
  input  logic                          abort,
  output logic [31:0]                   verinject__injector_state,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(SCHEDULE_DEPTH):0] entry_count,
  output logic [15:0]                   late_count,
  output logic                          load_error
);

  localparam int unsigned AddrWidth = $clog2(SCHEDULE_DEPTH);

  ctrl_state_e            state_q, state_d;
  logic [31:0]            bus_q, bus_d;
  logic [CYCLE_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic [15:0]            late_q, late_d;
  logic                   load_error_q, load_error_d;

  logic                   idle_or_done, accept, clear_act;
  logic                   wr_store, wr_reject, rewind, advance;
  logic [AddrWidth:0]     count;
  logic                   head_valid;
  logic [CYCLE_WIDTH-1:0] head_cycle;
  logic [31:0]            head_bit;

  assign idle_or_done = (state_q == StIdle) || (state_q == StDone);
  // Depth is a power of two, so the count MSB marks a full schedule.
  assign load_ready   = idle_or_done && !count[AddrWidth];
  assign accept       = load_valid && load_ready;
  assign clear_act    = sched_clear && idle_or_done;

  verinject_schedule_buffer #(
    .Depth      (SCHEDULE_DEPTH),
    .CycleWidth (CYCLE_WIDTH)
  ) u_schedule (
    .clock_i      (clock),
    .reset_i      (reset),
    .clear_i      (clear_act),
    .wr_valid_i   (accept),
    .wr_cycle_i   (load_cycle),
    .wr_bit_i     (load_bit),
    .wr_store_o   (wr_store),
    .wr_reject_o  (wr_reject),
    .rewind_i     (rewind),
    .advance_i    (advance),
    .count_o      (count),
    .head_valid_o (head_valid),
    .head_cycle_o (head_cycle),
    .head_bit_o   (head_bit)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // cnt_q is the run cycle n whose bus value is being computed; the CLEAR cycle computes n=0.
  always_comb begin
    state_d      = state_q;
    bus_d        = VERINJECT_STATE_IDLE;
    cnt_d        = cnt_q;
    late_d       = late_q;
    load_error_d = load_error_q;
    rewind       = 1'b0;
    advance      = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (clear_act) begin
          late_d       = '0;
          load_error_d = 1'b0;
        end else if (accept && wr_reject) begin
          load_error_d = 1'b1;
        end
        // A same-cycle store counts toward a non-empty schedule.
        if (start && !sched_clear && ((count != '0) || wr_store)) begin
          state_d = StClear;
          bus_d   = VERINJECT_STATE_CLEAR;
          cnt_d   = '0;
          rewind  = 1'b1;
        end
      end
      StClear, StRun: begin
        if ((state_q == StRun) && abort) begin
          state_d = StAbort;
          bus_d   = VERINJECT_STATE_CLEAR;
        end else if (!head_valid) begin
          state_d = StDone;
        end else begin
          state_d = StRun;
          cnt_d   = cnt_inc;
          if (head_cycle <= cnt_q) begin
            bus_d   = head_bit;
            advance = 1'b1;
            if ((head_cycle < cnt_q) && (late_q != '1)) begin
              late_d = late_q + 16'd1;
            end
          end
        end
      end
      StAbort: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      bus_q        <= VERINJECT_STATE_IDLE;
      cnt_q        <= '0;
      late_q       <= '0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus_q        <= bus_d;
      cnt_q        <= cnt_d;
      late_q       <= late_d;
      load_error_q <= load_error_d;
    end
  end

  assign verinject__injector_state = bus_q;
  assign busy        = (state_q == StClear) || (state_q == StRun) || (state_q == StAbort);
  assign done        = (state_q == StDone);
  assign entry_count = count;
  assign late_count  = late_q;
  assign load_error  = load_error_q;

endmodule

// File: tb/tb_verinject_injection_controller.sv
module tb_verinject_injection_controller;
  import verinject_pkg::*;

  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset, load_valid, load_ready, sched_clear, start, abort;
  logic [23:0] load_cycle;
  logic [31:0] load_bit, bus;
  logic        busy, done, load_error;
  logic [4:0]  entry_count;
  logic [15:0] late_count;

  int total = 0;
  int bad   = 0;

  // Reference model: the stored schedule plus flags.
  logic [23:0] m_cyc[$];
  logic [31:0] m_bit[$];
  logic        m_err;
  int          m_late;

  verinject_injection_controller #(
    .SCHEDULE_DEPTH (DEPTH),
    .CYCLE_WIDTH    (24)
  ) dut (
    .clock                     (clock),
    .reset                     (reset),
    .load_valid                (load_valid),
    .load_ready                (load_ready),
    .load_cycle                (load_cycle),
    .load_bit                  (load_bit),
    .sched_clear               (sched_clear),
    .start                     (start),
    .abort                     (abort),
    .verinject__injector_state (bus),
    .busy                      (busy),
    .done                      (done),
    .entry_count               (entry_count),
    .late_count                (late_count),
    .load_error                (load_error)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_cyc.delete();
    m_bit.delete();
    m_err  = 1'b0;
    m_late = 0;
  endtask

  // Applies the loading rules to a completed handshake.
  task automatic model_load(input logic [23:0] c, input logic [31:0] b);
    if (m_cyc.size() >= DEPTH) return;
    if (b >= 32'hFFFF_FFFE || (m_cyc.size() > 0 && c < m_cyc[$])) begin
      m_err = 1'b1;
    end else begin
      m_cyc.push_back(c);
      m_bit.push_back(b);
    end
  endtask

  task automatic load_entry(input logic [23:0] c, input logic [31:0] b);
    load_valid = 1'b1;
    load_cycle = c;
    load_bit   = b;
    chk("load_ready", {31'd0, load_ready}, {31'd0, m_cyc.size() < DEPTH});
    step();
    load_valid = 1'b0;
    model_load(c, b);
  endtask

  task automatic do_clear();
    sched_clear = 1'b1;
    step();
    sched_clear = 1'b0;
    m_cyc.delete();
    m_bit.delete();
    m_err  = 1'b0;
    m_late = 0;
  endtask

  // Start a run (optionally with a same-cycle load) and check the whole bus trace.
  task automatic run_and_check(input bit with_load, input logic [23:0] c, input logic [31:0] b);
    int          times[$];
    int          t_prev;
    int          t;
    logic [31:0] e;
    start = 1'b1;
    if (with_load) begin
      load_valid = 1'b1;
      load_cycle = c;
      load_bit   = b;
    end
    step();
    start      = 1'b0;
    load_valid = 1'b0;
    if (with_load) model_load(c, b);
    if (m_cyc.size() == 0) begin
      chk("start_ignored", {31'd0, busy}, 32'd0);
      return;
    end
    chk("clear_code", bus, VERINJECT_STATE_CLEAR);
    chk("clear_busy", {31'd0, busy}, 32'd1);
    chk("ready_low", {31'd0, load_ready}, 32'd0);
    // Emission time: own stamp, or one after the previous emission if that is later.
    t_prev = -1;
    foreach (m_cyc[i]) begin
      t = (int'(m_cyc[i]) > t_prev + 1) ? int'(m_cyc[i]) : t_prev + 1;
      if (t > int'(m_cyc[i])) m_late++;
      times.push_back(t);
      t_prev = t;
    end
    for (int n = 0; n <= t_prev; n++) begin
      step();
      e = VERINJECT_STATE_IDLE;
      foreach (times[i]) if (times[i] == n) e = m_bit[i];
      chk($sformatf("bus_n%0d", n), bus, e);
    end
    step();
    chk("done", {31'd0, done}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd0);
    chk("done_bus", bus, VERINJECT_STATE_IDLE);
    chk("late_count", {16'd0, late_count}, m_late);
    chk("entries_kept", {27'd0, entry_count}, m_cyc.size());
  endtask

  initial begin
    logic [23:0] c;
    logic [31:0] b;
    int          n;
    int          r;
    reset = 1'b1; load_valid = 1'b0; sched_clear = 1'b0; start = 1'b0; abort = 1'b0;
    load_cycle = '0; load_bit = '0;
    model_reset();
    step();
    step();
    chk("rst_bus", bus, 32'hFFFF_FFFF);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_entries", {27'd0, entry_count}, 32'd0);
    chk("rst_late", {16'd0, late_count}, 32'd0);
    chk("rst_err", {31'd0, load_error}, 32'd0);
    chk("rst_ready", {31'd0, load_ready}, 32'd1);
    reset = 1'b0;
    step();

    // Basic replay with an equal-stamp collision, then replay from DONE.
    do_clear();
    load_entry(24'd0, 32'd5);
    load_entry(24'd3, 32'd100);
    load_entry(24'd3, 32'd101);
    run_and_check(1'b0, '0, '0);
    chk("late_after_run1", {16'd0, late_count}, 32'd1);
    run_and_check(1'b0, '0, '0);

    // Rejected loads: bad bit index and decreasing stamp.
    do_clear();
    load_entry(24'd1, 32'd7);
    load_entry(24'd4, 32'd8);
    load_entry(24'd5, 32'hFFFF_FFFE);
    load_entry(24'd2, 32'd9);
    chk("err_entries", {27'd0, entry_count}, 32'd2);
    chk("err_flag", {31'd0, load_error}, 32'd1);
    do_clear();
    chk("err_cleared", {31'd0, load_error}, 32'd0);
    chk("clear_entries", {27'd0, entry_count}, 32'd0);

    // Fill to depth; the extra offer is not accepted.
    c = 24'd0;
    for (int i = 0; i < DEPTH; i++) begin
      c = c + 24'($urandom_range(0, 2));
      load_entry(c, 32'h1000 + 32'(i));
    end
    chk("full_ready", {31'd0, load_ready}, 32'd0);
    load_entry(c + 24'd1, 32'h2222);
    chk("full_entries", {27'd0, entry_count}, 32'd16);
    run_and_check(1'b0, '0, '0);

    // Abort during RUN n=2 with events pending at n=10.
    do_clear();
    load_entry(24'd10, 32'd33);
    load_entry(24'd10, 32'd44);
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_clear", bus, VERINJECT_STATE_CLEAR);
    chk("abort_busy", {31'd0, busy}, 32'd1);
    step();
    chk("abort_idle_busy", {31'd0, busy}, 32'd0);
    chk("abort_idle_done", {31'd0, done}, 32'd0);
    chk("abort_idle_ready", {31'd0, load_ready}, 32'd1);
    for (int i = 0; i < 12; i++) begin
      chk("abort_quiet", bus, VERINJECT_STATE_IDLE);
      step();
    end

    // Reset in the middle of a run.
    do_clear();
    load_entry(24'd2, 32'd11);
    load_entry(24'd20, 32'd12);
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    chk("mid_rst_bus", bus, VERINJECT_STATE_IDLE);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_entries", {27'd0, entry_count}, 32'd0);
    chk("mid_rst_ready", {31'd0, load_ready}, 32'd1);
    step();
    chk("mid_rst_quiet", bus, VERINJECT_STATE_IDLE);

    // Randomized schedules, some with a load in the start cycle.
    for (int it = 0; it < 10; it++) begin
      do_clear();
      n = $urandom_range(1, DEPTH);
      c = 24'd0;
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 9);
        b = $urandom();
        if (b >= 32'hFFFF_FFFE) b = 32'd0;
        if (r == 0) begin
          load_entry(c, 32'hFFFF_FFFE + 32'($urandom_range(0, 1)));
        end else if (r == 1 && c > 0) begin
          load_entry(c - 24'd1, b);
        end else begin
          c = c + 24'($urandom_range(0, 3));
          load_entry(c, b);
        end
      end
      chk("rnd_entries", {27'd0, entry_count}, m_cyc.size());
      chk("rnd_err", {31'd0, load_error}, {31'd0, m_err});
      b = $urandom_range(0, 32'hFFFF);
      run_and_check(it[0], c + 24'($urandom_range(0, 2)), b);
      if (it % 3 == 0) run_and_check(1'b0, '0, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
